// File: rtl/start_button_detector.sv
// start_button_detector
// Watches the tracked cursor and decides when the player has "pressed" the
// start-screen play button by dwelling inside it for DWELL_FRAMES consecutive
// hit frames. Emits a one-cycle start pulse plus hover/progress feedback.
module start_button_detector #(
    parameter int unsigned BTN_X        = 380,
    parameter int unsigned BTN_Y        = 500,
    parameter int unsigned BTN_W        = 200,
    parameter int unsigned BTN_H        = 100,
    parameter int unsigned DWELL_FRAMES = 60,
    parameter int unsigned LOSS_FRAMES  = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic        new_frame_in,
    input  logic        valid_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    output logic        hover_out,
    output logic [7:0]  progress_out,
    output logic        start_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HOVER = 2'd1,
        S_FIRED = 2'd2
    } state_t;

    // Button bounds held 12 bits wide so the right/bottom sums cannot wrap.
    localparam logic [11:0] X_LO  = 12'(BTN_X);
    localparam logic [11:0] X_HI  = 12'(BTN_X + BTN_W);
    localparam logic [11:0] Y_LO  = 12'(BTN_Y);
    localparam logic [11:0] Y_HI  = 12'(BTN_Y + BTN_H);
    localparam logic [7:0]  DWELL = 8'(DWELL_FRAMES);
    localparam logic [3:0]  LOSS  = 4'(LOSS_FRAMES);

    state_t      state_q, state_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [3:0]  miss_q, miss_d;
    logic        flag_q, flag_d;
    logic        hover_q, hover_d;
    logic        start_q, start_d;

    logic [11:0] x_ext;
    logic [11:0] y_ext;
    logic        in_box;
    logic        sample_hit;
    logic [7:0]  dwell_inc;
    logic [3:0]  miss_inc;

    // Hit test: inclusive left/top edges, exclusive right/bottom edges.
    always_comb begin
        x_ext      = {1'b0, x_in};
        y_ext      = {2'b00, y_in};
        in_box     = (x_ext >= X_LO) && (x_ext < X_HI) &&
                     (y_ext >= Y_LO) && (y_ext < Y_HI);
        sample_hit = valid_in && in_box;
        dwell_inc  = (dwell_q >= DWELL) ? DWELL : dwell_q + 8'd1;
        miss_inc   = miss_q + 4'd1;
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            dwell_q <= '0;
            miss_q  <= '0;
            flag_q  <= 1'b0;
            hover_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            miss_q  <= miss_d;
            flag_q  <= flag_d;
            hover_q <= hover_d;
            start_q <= start_d;
        end
    end

    // Next-state and counter update, evaluated once per frame boundary.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        miss_d  = miss_q;
        if (!enable_in) begin
            state_d = S_IDLE;
            dwell_d = '0;
            miss_d  = '0;
        end else if (new_frame_in) begin
            case (state_q)
                S_IDLE: begin
                    if (flag_q) begin
                        dwell_d = 8'd1;
                        miss_d  = '0;
                        state_d = (DWELL == 8'd1) ? S_FIRED : S_HOVER;
                    end
                end
                S_HOVER: begin
                    if (flag_q) begin
                        miss_d  = '0;
                        dwell_d = dwell_inc;
                        if (dwell_inc == DWELL) begin
                            state_d = S_FIRED;
                        end
                    end else if (miss_inc >= LOSS) begin
                        dwell_d = '0;
                        miss_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        miss_d = miss_inc;
                    end
                end
                S_FIRED: begin
                    dwell_d = DWELL;
                    if (flag_q) begin
                        miss_d = '0;
                    end else if (miss_inc >= LOSS) begin
                        dwell_d = '0;
                        miss_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        miss_d = miss_inc;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    dwell_d = '0;
                    miss_d  = '0;
                end
            endcase
        end
    end

    // Frame flag, hover tracking and press pulse.
    // FIRED is only ever entered by a press, so the entry transition is the pulse.
    always_comb begin
        flag_d  = flag_q;
        hover_d = hover_q;
        start_d = 1'b0;
        if (!enable_in) begin
            flag_d  = 1'b0;
            hover_d = 1'b0;
        end else begin
            if (new_frame_in) begin
                flag_d = sample_hit;
            end else if (sample_hit) begin
                flag_d = 1'b1;
            end
            if (valid_in) begin
                hover_d = in_box;
            end
            start_d = new_frame_in && (state_d == S_FIRED) && (state_q != S_FIRED);
        end
    end

    assign hover_out    = hover_q;
    assign progress_out = dwell_q;
    assign start_out    = start_q;

endmodule

// File: doc/start_button_detector.md
# start_button_detector

Input-side companion to the start-screen renderer. The renderer draws the orange play button; this block reads the player's tracked cursor position and decides when the player has "pressed" that button. A press means the cursor dwells inside the button rectangle for a set number of video frames. The block emits a one-cycle `start_out` pulse to the game-state controller, plus hover and progress outputs that the renderer can use for highlighting.

## Interface
Parameters:
- `BTN_X`, 380, left edge of the button in pixels (inclusive)
- `BTN_Y`, 500, top edge of the button in pixels (inclusive)
- `BTN_W`, 200, button width in pixels
- `BTN_H`, 100, button height in pixels
- `DWELL_FRAMES`, 60, consecutive-hit frames needed to fire; range 1..255
- `LOSS_FRAMES`, 4, consecutive miss frames that cancel a dwell or re-arm after a fire; range 1..15

Ports:
- `clk_in`  in  1  system clock; the only clock
- `rst_in`  in  1  synchronous, active-high reset
- `enable_in`  in  1  start screen is active; when low, the block is held idle
- `new_frame_in`  in  1  one-cycle pulse marking a frame boundary
- `valid_in`  in  1  the `x_in`/`y_in` sample is valid this cycle
- `x_in`  in  11  cursor x position
- `y_in`  in  10  cursor y position
- `hover_out`  out  1  registered: the most recent valid sample lies inside the button
- `progress_out`  out  8  dwell count of consecutive hit frames, from 0 to `DWELL_FRAMES`
- `start_out`  out  1  one-cycle press pulse

## Operation
- Hit test: `BTN_X <= x_in < BTN_X+BTN_W` and `BTN_Y <= y_in < BTN_Y+BTN_H`.
  - Bounds are computed 12 bits wide so that no sum wraps.
  - Edges are inclusive on the left/top and exclusive on the right/bottom.
- Frame hit flag:
  - Set by any valid in-box sample.
  - Cleared by `new_frame_in`.
  - A frame counts as a "hit" if at least one valid in-box sample arrived during it; otherwise it is a "miss", including frames with no valid samples.
- Counters: dwell (8 bits), miss (4 bits). Both are evaluated only on `new_frame_in`.
- States:
  - IDLE:
    - Hit frame: dwell=1, miss=0, go to HOVER.
    - If `DWELL_FRAMES`=1: fire immediately and go to FIRED.
  - HOVER:
    - Hit frame: dwell+1, miss=0.
    - Miss frame: miss+1. When miss reaches `LOSS_FRAMES`: dwell=0, go to IDLE. Dwell holds during a grace miss.
    - When dwell reaches `DWELL_FRAMES`: pulse `start_out`, go to FIRED.
  - FIRED:
    - `progress_out` holds at `DWELL_FRAMES`.
    - Hit frame: miss=0.
    - Miss frame: miss+1. At `LOSS_FRAMES`: dwell=0, miss=0, go to IDLE.
    - This forces the player to leave the button before another press can register.
- `enable_in` low:
  - Next cycle: state=IDLE, counters=0, frame flag=0, `hover_out`=0.
  - `start_out` is suppressed, even if a new frame fires in the same cycle.
- Reset (including mid-dwell or in FIRED): all state and outputs return to zero or IDLE. No pulse is produced.

## Timing
- Reset values: `hover_out`=0, `progress_out`=0, `start_out`=0, state=IDLE, flag=0, both counters=0.
- `hover_out` updates in the cycle after a valid sample and holds between samples.
- A `new_frame_in` at cycle t evaluates the flag as it stood before cycle t. State, counters, `progress_out` and `start_out` update at t+1. `start_out` is high only in cycle t+1.
- `valid_in` and `new_frame_in` in the same cycle: the sample counts toward the new frame. The flag is loaded with that sample's hit result instead of being cleared.
- Each frame is evaluated exactly once. Back-to-back `new_frame_in` pulses are legal; each one is a separate frame.
- The dwell counter saturates at `DWELL_FRAMES` and never wraps.
- Latency from the frame that completes the dwell to `start_out`: 1 cycle after its closing `new_frame_in`.

## Test plan
- Dwell fire:
  - Stimulus: cursor (480,550) valid in every frame for 60 frames.
  - Required: `progress_out` counts 1..60. `start_out` is high exactly once, one cycle after the 60th frame's closing pulse. State is FIRED.
- Edge test:
  - Samples (379,550), (580,550), (480,600): all misses, `hover_out`=0.
  - Samples (380,500), (579,599): both hits, `hover_out`=1.
- Grace and cancel:
  - Dwell to 30, then 3 miss frames, then a hit: `progress_out`=31.
  - Dwell to 30, then 4 miss frames: `progress_out`=0, state IDLE, no `start_out`.
- Re-arm:
  - After a fire, keep the cursor inside for 100 frames: no second pulse.
  - Then 4 miss frames, then 60 hit frames: a second pulse.
- Simultaneity:
  - `valid_in` in-box coincident with `new_frame_in`, no other samples: the closing frame is evaluated as a miss and the next frame as a hit.
- Reset and enable:
  - Assert `rst_in` at dwell 59: all outputs 0, and no pulse when the following hit frame arrives.
  - Drop `enable_in` during the firing frame: `start_out` stays 0.
